// File: rtl/axis_kx_packer_if.sv
// AXI-Stream bundle shared by the byte side and the packed kx side.
// DW sets the tdata width of each instance.
`timescale 1ns/1ps
interface axis_kx_packer_if #(
  parameter int DW = 8
) ();
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_kx_packer.sv
// Byte stream to {k, x} beat packer, LSB-first, with a one-deep
// output holding register and tlast-based framing checks.
`timescale 1ns/1ps
module axis_kx_packer #(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic clk,
  input  logic rst,
  axis_kx_packer_if.slave  s_axis,
  axis_kx_packer_if.master m_axis_kx,
  output logic frame_err
);

  localparam int W_KX   = R*C*W_K + C*W_X;
  localparam int NBYTES = (W_KX + 7) / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int AW     = (NBYTES - 1) * 8;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [CW-1:0]       cnt;
  logic [AW-1:0]       asm_q;
  logic [AW-1:0]       asm_d;
  logic [8*NBYTES-1:0] full;
  logic                kx_valid;
  logic [W_KX-1:0]     kx_data;
  logic                slot_free;
  logic                at_last;
  logic                accept;
  logic                complete;
  logic                early;

  assign slot_free = !kx_valid | m_axis_kx.tready;
  assign at_last   = (cnt == LAST);

  // Only the completing byte ever stalls; earlier bytes go to asm_q.
  assign s_axis.tready = !(at_last && !slot_free);

  assign accept   = s_axis.tvalid & s_axis.tready;
  assign complete = accept & at_last;
  assign early    = accept & s_axis.tlast & !at_last;

  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < NBYTES - 1; i++) begin
      if (cnt == CW'(i)) begin
        asm_d[i*8 +: 8] = s_axis.tdata;
      end
    end
  end

  // The completing byte is merged straight into the output beat.
  assign full = {s_axis.tdata, asm_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      asm_q     <= '0;
      kx_valid  <= 1'b0;
      kx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early | (complete & !s_axis.tlast);

      if (accept) begin
        asm_q <= asm_d;
        if (at_last || s_axis.tlast) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (complete) begin
        kx_valid <= 1'b1;
        kx_data  <= full[W_KX-1:0];
      end else if (kx_valid && m_axis_kx.tready) begin
        kx_valid <= 1'b0;
      end
    end
  end

  assign m_axis_kx.tvalid = kx_valid;
  assign m_axis_kx.tdata  = kx_data;
  assign m_axis_kx.tlast  = 1'b1;

endmodule

// File: tb/tb_axis_kx_packer.sv
// Directed bench for axis_kx_packer with R=C=2, 8-bit elements:
// 48-bit beats assembled from 6-byte frames.
`timescale 1ns/1ps
module tb_axis_kx_packer;

  localparam int R = 2;
  localparam int C = 2;
  localparam int WX = 8;
  localparam int WK = 8;
  localparam int WKX = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_err;

  axis_kx_packer_if #(.DW(8))   s_if ();
  axis_kx_packer_if #(.DW(WKX)) m_if ();

  axis_kx_packer #(
    .R(R), .C(C), .W_X(WX), .W_K(WK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_if.slave),
    .m_axis_kx(m_if.master),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int err_cnt = 0;
  logic fe_prev = 1'b0;
  logic [WKX-1:0] beats[$];
  int bcyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && m_if.tvalid && m_if.tready) begin
      beats.push_back(m_if.tdata);
      bcyc.push_back(cyc);
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (fe_prev) begin
      n_cmp++;
      assert (frame_err === 1'b0) else begin
        n_err++;
        $error("FAIL frame_err_held: observed %b expected 0", frame_err);
      end
    end
    fe_prev <= frame_err;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l,
                      output int waits);
    int k;
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = b;
    s_if.tlast  = l;
    k = 0;
    while (!s_if.tready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed stalled expected ready");
    end
    waits = k;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic l);
    int w;
    for (int i = 0; i < 6; i++) begin
      send(base + 8'(i), (i == 5) ? l : 1'b0, w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    int eb;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_s_tready", 64'(s_if.tready), 64'd1);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);

    // Basic frame
    m_if.tready = 1'b1;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, w);
    chk("basic_tvalid_pre", 64'(m_if.tvalid), 64'd0);
    send(8'h06, 1'b1, w);
    chk("basic_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("basic_tdata", 64'(m_if.tdata), 64'h060504030201);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_nbeats", 64'(beats.size()), 64'd1);
    chk("basic_beat", 64'(beats[0]), 64'h060504030201);
    chk("basic_no_err", 64'(err_cnt), 64'd0);

    // Backpressure, then same-cycle handshake and completion
    m_if.tready = 1'b0;
    send_frame(8'h21, 1'b1);
    chk("bp_a_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("bp_a_tdata", 64'(m_if.tdata), 64'h262524232221);
    wsum = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h31 + 8'(i), 1'b0, w);
      wsum += w;
    end
    chk("bp_b_no_stall", 64'(wsum), 64'd0);
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h36;
    s_if.tlast  = 1'b1;
    #1;
    chk("bp_stall", 64'(s_if.tready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_data", 64'(m_if.tdata), 64'h262524232221);
      chk("bp_hold_stall", 64'(s_if.tready), 64'd0);
    end
    m_if.tready = 1'b1;
    #1;
    chk("bp_release", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("same_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("same_tdata", 64'(m_if.tdata), 64'h363534333231);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_nbeats", 64'(beats.size()), 64'd3);
    chk("bp_beat_a", 64'(beats[1]), 64'h262524232221);
    chk("bp_beat_b", 64'(beats[2]), 64'h363534333231);
    chk("bp_consec", 64'(bcyc[2] - bcyc[1]), 64'd1);
    chk("bp_no_err", 64'(err_cnt), 64'd0);

    // Early tlast
    eb = err_cnt;
    send(8'hAA, 1'b0, w);
    send(8'hBB, 1'b0, w);
    send(8'hCC, 1'b1, w);
    chk("early_err_pulse", 64'(frame_err), 64'd1);
    @(posedge clk);
    #1;
    chk("early_err_clear", 64'(frame_err), 64'd0);
    chk("early_no_beat", 64'(m_if.tvalid), 64'd0);
    send_frame(8'h11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("early_nbeats", 64'(beats.size()), 64'd4);
    chk("early_next_beat", 64'(beats[3]), 64'h161514131211);
    chk("early_err_cnt", 64'(err_cnt - eb), 64'd1);

    // Missing tlast
    eb = err_cnt;
    send_frame(8'h41, 1'b0);
    chk("miss_err_pulse", 64'(frame_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("miss_nbeats", 64'(beats.size()), 64'd5);
    chk("miss_beat", 64'(beats[4]), 64'h464544434241);
    chk("miss_err_cnt", 64'(err_cnt - eb), 64'd1);

    // Reset mid-frame
    eb = err_cnt;
    send(8'h51, 1'b0, w);
    send(8'h52, 1'b0, w);
    send(8'h53, 1'b0, w);
    do_reset();
    chk("rst_mid_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_mid_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_mid_tready", 64'(s_if.tready), 64'd1);
    send_frame(8'h61, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_nbeats", 64'(beats.size()), 64'd6);
    chk("rst_mid_beat", 64'(beats[5]), 64'h666564636261);

    // Reset with a held beat
    m_if.tready = 1'b0;
    send_frame(8'h71, 1'b1);
    chk("rst_held_pre", 64'(m_if.tdata), 64'h767574737271);
    do_reset();
    chk("rst_held_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_held_tdata", 64'(m_if.tdata), 64'd0);
    m_if.tready = 1'b1;
    send_frame(8'h81, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_nbeats", 64'(beats.size()), 64'd7);
    chk("rst_held_beat", 64'(beats[6]), 64'h868584838281);
    chk("rst_no_err", 64'(err_cnt - eb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
